op_tx: RTL and testbench

Serial transmitter for 4-bit op codes: the stage directly upstream of the op receiver, driving the single-wire command line that the receiver samples. It accepts op codes from the host-side command source over a valid/ready handshake and buffers them in a small FIFO. Each op is serialized as a fixed 6-bit frame at one bit per `CLK_BAUD_RATIO` clock cycles.

---
 rtl/op_tx.sv | 143 ++++++++++++++
 tb/tb_op_tx.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/op_tx.sv
// op_tx: buffers 4-bit op codes in a small FIFO and serializes each one as a
// 6-bit frame (start=1, d0..d3 LSB first, stop=0) at CLK_BAUD_RATIO clocks per bit.
module op_tx #(
    parameter int CLK_BAUD_RATIO = 8,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [3:0] op_in,
    input  logic       op_valid_in,
    output logic       op_ready_out,
    output logic       tx_out,
    output logic       busy_out
);

    localparam int CW = $clog2(CLK_BAUD_RATIO);
    localparam int NW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);

    // IDLE: line 0, waiting | START: start bit | DATA: d0..d3 | STOP: stop bit
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam logic [CW-1:0] C_LAST = CW'(CLK_BAUD_RATIO - 1);
    localparam logic [NW-1:0] N_FULL = NW'(FIFO_DEPTH);

    logic [3:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [NW-1:0] r_count;
    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_bit_idx;
    logic [3:0]    r_shift;
    logic          r_tx;

    logic w_nonempty;
    logic w_bit_end;
    logic w_pop;
    logic w_push;

    assign w_nonempty = (r_count != '0);
    assign w_bit_end  = (r_cnt == C_LAST);
    // The head is popped on the same edge that launches the start bit.
    assign w_pop      = w_nonempty && ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));

    assign op_ready_out = (r_count != N_FULL) && !rst_in;
    assign w_push       = op_valid_in && op_ready_out;
    assign tx_out       = r_tx;
    assign busy_out     = (r_state != S_IDLE) || w_nonempty;

    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= op_in;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + NW'(1);
                2'b01:   r_count <= r_count - NW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b0;
                    if (w_nonempty) begin
                        r_shift <= r_mem[r_rd_ptr];
                        r_cnt   <= '0;
                        r_tx    <= 1'b1;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_cnt     <= '0;
                        r_tx      <= r_shift[0];
                        r_shift   <= {1'b0, r_shift[3:1]};
                        r_bit_idx <= 2'd0;
                        r_state   <= S_DATA;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_bit_idx == 2'd3) begin
                            r_tx    <= 1'b0;
                            r_state <= S_STOP;
                        end else begin
                            r_tx      <= r_shift[0];
                            r_shift   <= {1'b0, r_shift[3:1]};
                            r_bit_idx <= r_bit_idx + 2'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        // Chain straight into the next start bit when more ops wait.
                        if (w_nonempty) begin
                            r_shift <= r_mem[r_rd_ptr];
                            r_tx    <= 1'b1;
                            r_state <= S_START;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_op_tx.sv
// Bench for op_tx: an R=8 instance checked through a frame-decoding scoreboard
// and per-cycle line checks, plus an R=2 instance for the minimum bit period.
module tb_op_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] op_a, op_b;
    logic       vld_a, vld_b;
    logic       rdy_a, rdy_b;
    logic       tx_a, tx_b;
    logic       busy_a, busy_b;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int t0, s1, s2, bad;
    bit tk;
    logic [3:0] exp_q[$];

    op_tx #(.CLK_BAUD_RATIO(8), .FIFO_DEPTH(4)) u_a (
        .clk_in(clk), .rst_in(rst), .op_in(op_a), .op_valid_in(vld_a),
        .op_ready_out(rdy_a), .tx_out(tx_a), .busy_out(busy_a)
    );

    op_tx #(.CLK_BAUD_RATIO(2), .FIFO_DEPTH(4)) u_b (
        .clk_in(clk), .rst_in(rst), .op_in(op_b), .op_valid_in(vld_b),
        .op_ready_out(rdy_b), .tx_out(tx_b), .busy_out(busy_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Line level after edge k of a frame whose op was pushed at edge 0.
    function automatic logic exp_line(input logic [3:0] op, input int k, input int r);
        int b;
        if (k < 1 || k > 6 * r) return 1'b0;
        b = (k - 1) / r;
        if (b == 0) return 1'b1;
        if (b == 5) return 1'b0;
        return op[b-1];
    endfunction

    // Offer op for up to max_wait edges; record it as expected only on a handshake.
    task automatic drive_op(input logic [3:0] op, input int max_wait, output bit taken);
        logic rdy;
        op_a  = op;
        vld_a = 1'b1;
        taken = 1'b0;
        for (int i = 0; i < max_wait && !taken; i++) begin
            rdy = rdy_a;
            step();
            if (rdy) begin
                taken = 1'b1;
                exp_q.push_back(op);
            end
        end
        vld_a = 1'b0;
    endtask

    task automatic rx_frame(input int r, output logic [3:0] d, output bit shape_ok, output int start_cyc);
        bit   found;
        logic v;
        found     = 1'b0;
        shape_ok  = 1'b1;
        d         = 4'h0;
        start_cyc = -1;
        for (int i = 0; i < 400 && !found; i++) begin
            step();
            if (tx_a === 1'b1) found = 1'b1;
        end
        chk("rx_start_seen", found, 1);
        if (!found) return;
        start_cyc = cyc;
        for (int i = 1; i < r; i++) begin
            step();
            if (tx_a !== 1'b1) shape_ok = 1'b0;
        end
        for (int b = 0; b < 4; b++) begin
            step();
            v    = tx_a;
            d[b] = v;
            for (int i = 1; i < r; i++) begin
                step();
                if (tx_a !== v) shape_ok = 1'b0;
            end
        end
        for (int i = 0; i < r; i++) begin
            step();
            if (tx_a !== 1'b0) shape_ok = 1'b0;
        end
    endtask

    task automatic rx_check(input string tag, output int sc);
        logic [3:0] d;
        bit         ok;
        rx_frame(8, d, ok, sc);
        chk({tag, "_shape"}, ok, 1);
        chk({tag, "_sb_pending"}, exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk({tag, "_data"}, d, exp_q.pop_front());
    endtask

    initial begin
        rst = 1'b1; vld_a = 1'b0; op_a = 4'h0; vld_b = 1'b0; op_b = 4'h0;
        repeat (3) step();
        vld_a = 1'b1; vld_b = 1'b1;
        #1;
        chk("rst_tx_a", tx_a, 0);
        chk("rst_busy_a", busy_a, 0);
        chk("rst_ready_a", rdy_a, 0);
        chk("rst_tx_b", tx_b, 0);
        chk("rst_busy_b", busy_b, 0);
        chk("rst_ready_b", rdy_b, 0);
        vld_a = 1'b0; vld_b = 1'b0;
        rst = 1'b0;
        step(); step();
        chk("idle_ready_a", rdy_a, 1);
        chk("idle_busy_a", busy_a, 0);

        // Single op 4'b1011, cycle-exact line and busy profile
        op_a = 4'hB; vld_a = 1'b1;
        step();
        vld_a = 1'b0;
        for (int k = 1; k <= 56; k++) begin
            step();
            chk($sformatf("single_tx_k%0d", k), tx_a, exp_line(4'hB, k, 8));
            if (k < 48) chk($sformatf("single_busy_k%0d", k), busy_a, 1);
            if (k > 48) chk($sformatf("single_busy_k%0d", k), busy_a, 0);
        end

        // Back-to-back A then 5
        fork
            begin
                drive_op(4'hA, 10, tk);
                t0 = cyc;
                drive_op(4'h5, 10, tk);
            end
            begin
                rx_check("b2b_f0", s1);
                rx_check("b2b_f1", s2);
            end
        join
        chk("b2b_latency", s1 - t0, 1);
        chk("b2b_gap", s2 - s1, 48);
        step();
        chk("b2b_idle_busy", busy_a, 0);

        // FIFO full, dropped op, then push on the pop edge while full
        fork
            begin
                for (int i = 1; i <= 5; i++) begin
                    drive_op(4'(i), 10, tk);
                    chk($sformatf("full_take%0d", i), tk, 1);
                    if (i == 1) t0 = cyc;
                end
                chk("full_ready_low", rdy_a, 0);
                drive_op(4'd6, 20, tk);
                chk("full_drop6", tk, 0);
                while (cyc < t0 + 48) step();
                chk("pp_ready_before", rdy_a, 0);
                drive_op(4'd7, 1, tk);
                chk("pp_drop7", tk, 0);
                chk("pp_ready_after", rdy_a, 1);
                drive_op(4'd8, 1, tk);
                chk("pp_take8", tk, 1);
                chk("pp_ready_full_again", rdy_a, 0);
            end
            begin
                for (int i = 0; i < 6; i++) rx_check($sformatf("full_f%0d", i), s1);
            end
        join
        chk("full_sb_drained", exp_q.size(), 0);
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (tx_a !== 1'b0 || busy_a !== 1'b0) bad++;
        end
        chk("full_no_extra_frames", bad, 0);

        // Reset during d2 with two ops queued
        drive_op(4'h7, 10, tk);
        t0 = cyc;
        drive_op(4'hC, 10, tk);
        drive_op(4'h6, 10, tk);
        while (cyc < t0 + 28) step();
        chk("rst_mid_pre_tx", tx_a, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_tx", tx_a, 0);
        chk("rst_mid_busy", busy_a, 0);
        chk("rst_mid_ready", rdy_a, 0);
        step(); step();
        rst = 1'b0;
        exp_q.delete();
        bad = 0;
        for (int i = 0; i < 80; i++) begin
            step();
            if (tx_a !== 1'b0 || busy_a !== 1'b0) bad++;
        end
        chk("rst_post_idle", bad, 0);
        chk("rst_post_ready", rdy_a, 1);
        fork
            drive_op(4'h3, 10, tk);
            rx_check("rst_new", s1);
        join

        // R=2 minimum: op 0 gives 2 high then 10 low
        chk("r2_ready", rdy_b, 1);
        op_b = 4'h0; vld_b = 1'b1;
        step();
        vld_b = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step();
            chk($sformatf("r2_tx_k%0d", k), tx_b, exp_line(4'h0, k, 2));
            if (k == 1 || k == 11) chk($sformatf("r2_busy_k%0d", k), busy_b, 1);
            if (k >= 13) chk($sformatf("r2_busy_k%0d", k), busy_b, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
